// File: rtl/mmio_button_in.sv
// mmio_button_in
// Memory-mapped push-button input peripheral. Raw button levels are
// synchronized, debounced per bit, and turned into sticky press/release
// event flags plus a 16-bit press counter. The CPU reads everything through
// a combinational read port; the event flags clear when read.
//
// Ports
//   clk      system clock
//   rst      asynchronous reset, active-high
//   btn_raw  raw asynchronous button levels, 1 = pressed
//   rd_en    read strobe for this peripheral (address decoded outside)
//   rd_addr  word select: 0 STATE, 1 PRESS, 2 RELEASE, 3 COUNT
//   rd_data  read data, combinational from rd_addr
//   irq      OR of all press and release flag bits
//
// Read handshake: there is no valid/ready pair. rd_data is always valid for
// the current rd_addr, with no wait states. rd_en only qualifies the
// side effect: on a clk edge with rd_en=1, the flag word selected by rd_addr
// (PRESS or RELEASE) is cleared. rd_data in that cycle still shows the
// value before the clear.
module mmio_button_in #(
  parameter int N_BTN    = 4,
  parameter int DB_WIDTH = 16,
  parameter int DB_COUNT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             rd_en,
  input  logic [1:0]       rd_addr,
  output logic [31:0]      rd_data,
  output logic             irq
);

  localparam logic [1:0] ADDR_STATE   = 2'd0;
  localparam logic [1:0] ADDR_PRESS   = 2'd1;
  localparam logic [1:0] ADDR_RELEASE = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  // Counter value on the last mismatching cycle before a level is accepted.
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 1);

  logic [N_BTN-1:0]    sync1;
  logic [N_BTN-1:0]    sync2;
  logic [N_BTN-1:0]    stable;
  logic [DB_WIDTH-1:0] cnt [N_BTN];
  logic [N_BTN-1:0]    accept;
  logic [N_BTN-1:0]    rise;
  logic [N_BTN-1:0]    fall;
  logic [N_BTN-1:0]    press_flags;
  logic [N_BTN-1:0]    release_flags;
  logic [15:0]         press_count;
  logic [15:0]         rise_pop;
  logic                clr_press;
  logic                clr_release;

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // A bit is accepted on the DB_COUNT-th consecutive mismatching cycle.
  // Since accept already implies sync2 != stable, the new level alone tells
  // the edge direction.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == DB_LAST);
    end
    rise = accept & sync2;
    fall = accept & ~sync2;
  end

  // Debounce: any matching cycle restarts the run of mismatches from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_WIDTH'(1);
        end
      end
    end
  end

  // Number of buttons accepted as pressed on this edge.
  always_comb begin
    rise_pop = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rise_pop = rise_pop + 16'(rise[i]);
    end
  end

  assign clr_press   = rd_en && (rd_addr == ADDR_PRESS);
  assign clr_release = rd_en && (rd_addr == ADDR_RELEASE);

  // New events are OR-ed in after the clear, so an event landing on the
  // clearing edge survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_flags   <= '0;
      release_flags <= '0;
      press_count   <= '0;
    end else begin
      press_flags   <= (clr_press   ? '0 : press_flags)   | rise;
      release_flags <= (clr_release ? '0 : release_flags) | fall;
      press_count   <= press_count + rise_pop;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_STATE:   rd_data[N_BTN-1:0] = stable;
      ADDR_PRESS:   rd_data[N_BTN-1:0] = press_flags;
      ADDR_RELEASE: rd_data[N_BTN-1:0] = release_flags;
      ADDR_COUNT:   rd_data[15:0]      = press_count;
      default:      rd_data            = '0;
    endcase
  end

  assign irq = (|press_flags) | (|release_flags);

endmodule
